// File: rtl/wb_cmd_master.sv
// wb_cmd_master -- Wishbone classic single-transfer initiator.
//
// Takes one command (address, write data, byte selects, direction) on a
// valid/ready port and runs a single CYC/STB cycle on the Wishbone master
// port. It then waits for ACK, giving up after TIMEOUT cycles. The read data,
// or a timeout flag, is returned on a valid/ready response port. Only one
// transfer is outstanding at a time.
//
// Ports
//   wb_clk_i, wb_rst_ni         clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_we_i, cmd_sel_i,
//   cmd_adr_i, cmd_dat_i        command fields
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_dat_o, rsp_timeout_o    read data (0 for writes/timeouts), timeout flag
//   wbm_cyc_o, wbm_stb_o,
//   wbm_we_o, wbm_sel_o,
//   wbm_adr_o, wbm_dat_o        Wishbone master outputs
//   wbm_ack_i, wbm_dat_i        Wishbone master inputs
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a command, bus idle
// ST_BUS   | CYC/STB asserted, waiting for ACK or timeout
// ST_RESP  | response presented, waiting for rsp_ready_i

module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_timeout_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int SW = DW / 8;
    localparam int CW = 16;
    // The counter holds the number of ACK-less STB cycles already completed,
    // so the cycle in which it equals TIMEOUT-1 is the last one allowed.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic            rsp_to_q, rsp_to_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_to_d    = rsp_to_q;

        case (state_q)
            ST_IDLE: begin
                // ready_q leaves reset at 0 and rises on the first edge in IDLE
                ready_d = 1'b1;
                if (cmd_valid_i && ready_q) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // ACK takes priority over a timeout on the same edge
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_to_d    = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_to_d    = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                ready_d     = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // Classic single transfers: STB is always coincident with CYC
    assign cmd_ready_o   = ready_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_timeout_o = rsp_to_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [SW-1:0]   cmd_sel;
    logic [AW-1:0]   cmd_adr;
    logic [DW-1:0]   cmd_dat;
    logic            rsp_valid, rsp_ready, rsp_to;
    logic [DW-1:0]   rsp_dat;
    logic            cyc, stb, we;
    logic [SW-1:0]   sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_o, dat_i;
    logic            ack;

    // slave model controls
    logic            never_ack;
    logic            stray_ack;
    logic            mem_init;
    int              ack_delay;
    int              stb_cycles;
    int              stb_total;
    int              hs_cnt;
    logic [DW-1:0]   mem [16];
    logic [DW-1:0]   exp_mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_sel_i     (cmd_sel),
        .cmd_adr_i     (cmd_adr),
        .cmd_dat_i     (cmd_dat),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_dat_o     (rsp_dat),
        .rsp_timeout_o (rsp_to),
        .wbm_cyc_o     (cyc),
        .wbm_stb_o     (stb),
        .wbm_we_o      (we),
        .wbm_sel_o     (sel),
        .wbm_adr_o     (adr),
        .wbm_dat_o     (dat_o),
        .wbm_ack_i     (ack),
        .wbm_dat_i     (dat_i)
    );

    assign ack   = stray_ack | (!never_ack && stb && (stb_cycles == ack_delay));
    assign dat_i = mem[adr[5:2]];

    always @(posedge clk) begin
        if (stb && !ack) stb_cycles <= stb_cycles + 1;
        else             stb_cycles <= 0;
        if (stb) stb_total <= stb_total + 1;
        if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1234_5678 + 32'(i) * 32'h0101_0101;
        end else if (stb && ack && we) begin
            for (int b = 0; b < SW; b++)
                if (sel[b]) mem[adr[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    // Issue one command and wait (bounded) for the response; leaves it pending.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output int stbc);
        int n;
        int s0;
        n = 0;
        cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        s0 = stb_total;
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin tick(); lat++; end
        chk("rsp_wait_bound", 32'(lat < 50), 32'd1);
        stbc = stb_total - s0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, stbc, hs0, bad_stable, bad_rdy, bad_cyc;
        logic [31:0] snap_dat;
        logic        snap_to;
        logic        rw;
        int          idx;
        logic [31:0] rd;
        logic [3:0]  rs;

        rst_n = 1'b0; mem_init = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; never_ack = 1'b0; stray_ack = 1'b0; ack_delay = 0;
        stb_cycles = 0; stb_total = 0; hs_cnt = 0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h1234_5678 + 32'h0101_0101 * 32'(i);
        repeat (3) tick();

        // reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_to", 32'(rsp_to), 32'd0);
        chk("rst_adr", adr, 32'd0);
        mem_init = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // zero-wait write
        ack_delay = 0;
        cmd_we = 1'b1; cmd_adr = 32'h3000_0004; cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("wr_cyc", 32'(cyc), 32'd1);
        chk("wr_stb", 32'(stb), 32'd1);
        chk("wr_adr", adr, 32'h3000_0004);
        chk("wr_dat", dat_o, 32'hDEAD_BEEF);
        chk("wr_we", 32'(we), 32'd1);
        chk("wr_sel", 32'(sel), 32'hF);
        chk("wr_busy_ready", 32'(cmd_ready), 32'd0);
        chk("wr_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("wr_cyc_end", 32'(cyc), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_dat", rsp_dat, 32'd0);
        chk("wr_rsp_to", 32'(rsp_to), 32'd0);
        exp_mem[1] = 32'hDEAD_BEEF;
        finish_rsp();
        chk("wr_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("wr_ready_again", 32'(cmd_ready), 32'd1);

        // read with 3 wait states
        ack_delay = 3;
        run_cmd(1'b0, 32'h3000_0000, 32'd0, 4'hF, lat, stbc);
        chk("rd_stb_cycles", 32'(stbc), 32'd4);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_dat", rsp_dat, 32'h1234_5678);
        chk("rd_to", 32'(rsp_to), 32'd0);
        finish_rsp();

        // timeout
        never_ack = 1'b1;
        run_cmd(1'b0, 32'h3000_0008, 32'd0, 4'hF, lat, stbc);
        chk("to_stb_cycles", 32'(stbc), 32'(TO));
        chk("to_flag", 32'(rsp_to), 32'd1);
        chk("to_dat", rsp_dat, 32'd0);
        chk("to_cyc", 32'(cyc), 32'd0);
        finish_rsp();
        never_ack = 1'b0;
        ack_delay = 1;
        run_cmd(1'b0, 32'h3000_0004, 32'd0, 4'hF, lat, stbc);
        chk("post_to_rd_dat", rsp_dat, 32'hDEAD_BEEF);
        chk("post_to_rd_to", 32'(rsp_to), 32'd0);
        finish_rsp();

        // ACK on the very last allowed cycle wins over timeout
        ack_delay = TO - 1;
        run_cmd(1'b0, 32'h3000_000C, 32'd0, 4'hF, lat, stbc);
        chk("edge_ack_to", 32'(rsp_to), 32'd0);
        chk("edge_ack_dat", rsp_dat, exp_mem[3]);
        chk("edge_ack_stb", 32'(stbc), 32'(TO));
        finish_rsp();

        // response backpressure
        ack_delay = 0;
        run_cmd(1'b0, 32'h3000_0008, 32'd0, 4'hF, lat, stbc);
        snap_dat = rsp_dat; snap_to = rsp_to;
        chk("bp_dat", snap_dat, exp_mem[2]);
        cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_valid = 1'b1;
        bad_stable = 0; bad_rdy = 0; bad_cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_dat !== snap_dat || rsp_to !== snap_to) bad_stable++;
            if (cmd_ready !== 1'b0) bad_rdy++;
            if (cyc !== 1'b0) bad_cyc++;
        end
        cmd_valid = 1'b0;
        chk("bp_rsp_stable", 32'(bad_stable), 32'd0);
        chk("bp_cmd_ready_low", 32'(bad_rdy), 32'd0);
        chk("bp_no_cyc", 32'(bad_cyc), 32'd0);
        finish_rsp();

        // stray ACK in IDLE
        hs0 = hs_cnt;
        stray_ack = 1'b1;
        repeat (3) tick();
        stray_ack = 1'b0;
        chk("stray_idle_ready", 32'(cmd_ready), 32'd1);
        chk("stray_idle_cyc", 32'(cyc), 32'd0);
        chk("stray_idle_rsp", 32'(rsp_valid), 32'd0);
        chk("stray_idle_hs", 32'(hs_cnt), 32'(hs0));

        // stray ACK in RESP
        run_cmd(1'b0, 32'h3000_0014, 32'd0, 4'hF, lat, stbc);
        snap_dat = rsp_dat;
        stray_ack = 1'b1;
        repeat (3) tick();
        stray_ack = 1'b0;
        chk("stray_resp_valid", 32'(rsp_valid), 32'd1);
        chk("stray_resp_dat", rsp_dat, exp_mem[5]);
        chk("stray_resp_cyc", 32'(cyc), 32'd0);
        chk("stray_resp_ready", 32'(cmd_ready), 32'd0);
        finish_rsp();

        // async reset in the middle of a bus cycle
        never_ack = 1'b1;
        cmd_we = 1'b1; cmd_adr = 32'h3000_0018; cmd_dat = 32'hA5A5_A5A5; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("arst_pre_cyc", 32'(cyc), 32'd1);
        hs0 = hs_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(cyc), 32'd0);
        chk("arst_stb", 32'(stb), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        never_ack = 1'b0;
        tick();
        chk("arst_ready_after", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        repeat (10) tick();
        rsp_ready = 1'b0;
        chk("arst_no_rsp", 32'(hs_cnt), 32'(hs0));
        chk("arst_no_cyc", 32'(cyc), 32'd0);

        // back-to-back random traffic against the memory model
        for (int k = 0; k < 100; k++) begin
            rw = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            rd = $urandom;
            rs = 4'($urandom_range(1, 15));
            ack_delay = $urandom_range(0, 3);
            run_cmd(rw, 32'h3000_0000 + 32'(idx) * 32'd4, rd, rs, lat, stbc);
            if (rw) begin
                exp_mem[idx] = merge(exp_mem[idx], rd, rs);
                chk("rnd_wr_dat", rsp_dat, 32'd0);
            end else begin
                chk("rnd_rd_dat", rsp_dat, exp_mem[idx]);
            end
            chk("rnd_to", 32'(rsp_to), 32'd0);
            finish_rsp();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
